// File: rtl/reg_file_sb_pkg.sv
// Shared types and default sizing for the register file with scoreboard.
// The state enum is used by the top-level FSM.
package reg_file_sb_pkg;

    typedef enum logic {CLEAR, READY} e_rf_state;

    localparam int RF_WIDTH = 8;
    localparam int RF_DEPTH = 4;

endpackage

// File: rtl/reg_file_sb_rf_scoreboard.sv
// Per-register pending bits. A reservation (set) wins over a writeback (clear)
// to the same register; a flush drops every outstanding reservation at once.
module rf_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [DEPTH-1:0] pending
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (set_en && set_addr == AW'(i)) begin
                    pending[i] <= 1'b1;
                end else if (clr_en && clr_addr == AW'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with write-to-read bypass, pending scoreboard and a sequenced
// clear that zeroes one entry per cycle before the file reports ready.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int RD_PORTS = 2,
    parameter int ZERO_R0  = 0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr_req,
    output logic                               ready,
    input  logic [RD_PORTS-1:0][AW-1:0]        rd_addr,
    output logic [RD_PORTS-1:0][WIDTH-1:0]     rd_data,
    output logic [RD_PORTS-1:0]                rd_valid,
    input  logic                               wr_en,
    input  logic [AW-1:0]                      wr_addr,
    input  logic [WIDTH-1:0]                   wr_data,
    input  logic                               rsv_en,
    input  logic [AW-1:0]                      rsv_addr
);

    e_rf_state        state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             accept;
    logic             do_write;
    logic             do_rsv;
    logic             flush;

    // Writes and reservations only land in READY and never alongside a clear request.
    assign accept   = (state == READY) && !clr_req;
    assign do_write = accept && wr_en  && !((ZERO_R0 != 0) && wr_addr  == '0);
    assign do_rsv   = accept && rsv_en && !((ZERO_R0 != 0) && rsv_addr == '0);
    assign flush    = (state == READY) && clr_req;
    assign ready    = (state == READY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= READY;
                    end
                end
                READY: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; the clear sequence is what initialises it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (do_write) begin
            mem[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .DEPTH(DEPTH)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .set_en  (do_rsv),
        .set_addr(rsv_addr),
        .clr_en  (do_write),
        .clr_addr(wr_addr),
        .pending (pending)
    );

    always_comb begin
        rd_data  = '0;
        rd_valid = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            if (state != READY) begin
                rd_data[p]  = '0;
                rd_valid[p] = 1'b0;
            end else if ((ZERO_R0 != 0) && rd_addr[p] == '0) begin
                rd_data[p]  = '0;
                rd_valid[p] = 1'b1;
            end else if (wr_en && wr_addr == rd_addr[p]) begin
                rd_data[p]  = wr_data;
                rd_valid[p] = 1'b1;
            end else begin
                rd_data[p]  = mem[rd_addr[p]];
                rd_valid[p] = !pending[rd_addr[p]];
            end
        end
    end

endmodule
